// File: rtl/sha256_mem_responder.sv
// Word-addressed memory on the far side of the SHA-256 engine's memory port.
// Engine reads with 1-cycle latency; a host port loads and reads back data.
// Also tracks write-back of the digest window.
module sha256_mem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned OUT_WORDS = 8,
  parameter logic [31:0] OOB_DATA  = 32'hDEADBEEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 engine_active,
  input  logic [15:0]          mem_addr,
  input  logic                 mem_we,
  input  logic [31:0]          mem_write_data,
  output logic [31:0]          mem_read_data,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [15:0]          host_addr,
  input  logic [31:0]          host_wdata,
  output logic                 host_gnt,
  output logic                 host_rvalid,
  output logic [31:0]          host_rdata,
  input  logic [15:0]          out_base,
  output logic [OUT_WORDS-1:0] capture_mask,
  output logic                 capture_done,
  output logic                 err_oob
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned MW = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;

  logic [31:0] mem [DEPTH];

  logic [31:0]          mem_read_data_q, mem_read_data_d;
  logic                 host_rvalid_q, host_rvalid_d;
  logic [31:0]          host_rdata_q, host_rdata_d;
  logic [OUT_WORDS-1:0] capture_mask_q, capture_mask_d;
  logic                 capture_done_q, capture_done_d;
  logic                 err_oob_q, err_oob_d;
  logic                 active_q, active_d;

  logic        eng_in_range_c, host_in_range_c;
  logic        eng_wr_c, host_wr_c, in_win_c, active_rise_c;
  logic [16:0] win_off_c;

  // Arbitration, range checks and digest window decode
  always_comb begin
    eng_in_range_c  = 32'(mem_addr) < DEPTH;
    host_in_range_c = 32'(host_addr) < DEPTH;
    host_gnt        = host_req & ~engine_active;
    eng_wr_c        = engine_active & mem_we & eng_in_range_c;
    host_wr_c       = host_gnt & host_we & host_in_range_c;
    win_off_c       = 17'(mem_addr) - 17'(out_base);
    in_win_c        = (mem_addr >= out_base) && (win_off_c < 17'(OUT_WORDS));
    active_rise_c   = engine_active & ~active_q;
  end

  // Next-state for all registered outputs
  always_comb begin
    mem_read_data_d = eng_in_range_c ? mem[mem_addr[AW-1:0]] : OOB_DATA;
    host_rvalid_d   = host_gnt & ~host_we;
    host_rdata_d    = host_rdata_q;
    err_oob_d       = err_oob_q;
    capture_mask_d  = capture_mask_q;
    capture_done_d  = &capture_mask_q;
    active_d        = engine_active;

    if (host_rvalid_d) begin
      host_rdata_d = host_in_range_c ? mem[host_addr[AW-1:0]] : OOB_DATA;
    end
    if ((engine_active && !eng_in_range_c) || (host_gnt && !host_in_range_c)) begin
      err_oob_d = 1'b1;
    end
    // A new engine run restarts digest tracking
    if (active_rise_c) begin
      capture_mask_d = '0;
      capture_done_d = 1'b0;
    end else if (eng_wr_c && in_win_c) begin
      capture_mask_d[win_off_c[MW-1:0]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_read_data_q <= '0;
      host_rvalid_q   <= 1'b0;
      host_rdata_q    <= '0;
      capture_mask_q  <= '0;
      capture_done_q  <= 1'b0;
      err_oob_q       <= 1'b0;
      active_q        <= 1'b0;
    end else begin
      mem_read_data_q <= mem_read_data_d;
      host_rvalid_q   <= host_rvalid_d;
      host_rdata_q    <= host_rdata_d;
      capture_mask_q  <= capture_mask_d;
      capture_done_q  <= capture_done_d;
      err_oob_q       <= err_oob_d;
      active_q        <= active_d;
    end
  end

  // Array is not reset; engine and host writes are mutually exclusive by arbitration
  always_ff @(posedge clk) begin
    if (eng_wr_c) begin
      mem[mem_addr[AW-1:0]] <= mem_write_data;
    end
    if (host_wr_c) begin
      mem[host_addr[AW-1:0]] <= host_wdata;
    end
  end

  assign mem_read_data = mem_read_data_q;
  assign host_rvalid   = host_rvalid_q;
  assign host_rdata    = host_rdata_q;
  assign capture_mask  = capture_mask_q;
  assign capture_done  = capture_done_q;
  assign err_oob       = err_oob_q;

endmodule

// File: tb/tb_sha256_mem_responder.sv
// Directed self-checking bench for sha256_mem_responder.
module tb_sha256_mem_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        engine_active;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        host_req;
  logic        host_we;
  logic [15:0] host_addr;
  logic [31:0] host_wdata;
  logic        host_gnt;
  logic        host_rvalid;
  logic [31:0] host_rdata;
  logic [15:0] out_base;
  logic [7:0]  capture_mask;
  logic        capture_done;
  logic        err_oob;

  int n_tests = 0;
  int n_fail  = 0;

  sha256_mem_responder dut (
    .clk(clk), .reset_n(reset_n), .engine_active(engine_active),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_gnt(host_gnt),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata), .out_base(out_base),
    .capture_mask(capture_mask), .capture_done(capture_done), .err_oob(err_oob)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [15:0] a, input logic [31:0] d);
    host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
    step();
    host_req = 1'b0; host_we = 1'b0;
  endtask

  task automatic eng_write(input logic [15:0] a, input logic [31:0] d);
    mem_addr = a; mem_we = 1'b1; mem_write_data = d;
    step();
    mem_we = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdata_eng"}, mem_read_data, 32'h0);
    chk({tag, "_rvalid"},    32'(host_rvalid), 32'h0);
    chk({tag, "_rdata_host"}, host_rdata, 32'h0);
    chk({tag, "_mask"},      32'(capture_mask), 32'h0);
    chk({tag, "_done"},      32'(capture_done), 32'h0);
    chk({tag, "_err"},       32'(err_oob), 32'h0);
  endtask

  logic [15:0] cap_addr [10] = '{16'h103, 16'h100, 16'h107, 16'h101, 16'h103,
                                 16'h102, 16'h108, 16'h104, 16'h105, 16'h106};
  logic [7:0]  cap_mask [10] = '{8'h08, 8'h09, 8'h89, 8'h8B, 8'h8B,
                                 8'h8F, 8'h8F, 8'h9F, 8'hBF, 8'hFF};

  initial begin
    int gnt_seen;
    reset_n = 1'b0; engine_active = 1'b0; mem_addr = '0; mem_we = 1'b0;
    mem_write_data = '0; host_req = 1'b0; host_we = 1'b0; host_addr = '0;
    host_wdata = '0; out_base = 16'h0100;
    #12;
    chk_all_zero("reset");
    reset_n = 1'b1;
    step();

    // Host load and readback
    for (int i = 0; i < 20; i++) host_write(16'(i), 32'(i));
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'd5;
    #1;
    chk("host_gnt_idle", 32'(host_gnt), 32'h1);
    step();
    host_req = 1'b0;
    chk("host_rvalid", 32'(host_rvalid), 32'h1);
    chk("host_rdata5", host_rdata, 32'h5);
    step();
    chk("host_rvalid_drop", 32'(host_rvalid), 32'h0);

    // Engine streaming, then read-first collision
    engine_active = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_addr = 16'(i);
      step();
      chk($sformatf("eng_rd%0d", i), mem_read_data, 32'(i));
    end
    eng_write(16'd7, 32'hA5A5A5A5);
    chk("eng_rfw_old", mem_read_data, 32'h7);
    step();
    chk("eng_rfw_new", mem_read_data, 32'hA5A5A5A5);

    // Digest capture, out of order with a repeat and one outside the window
    chk("cap_start", 32'(capture_mask), 32'h0);
    for (int i = 0; i < 10; i++) begin
      eng_write(cap_addr[i], 32'hC0DE0000 | 32'(i));
      chk($sformatf("cap_mask%0d", i), 32'(capture_mask), 32'(cap_mask[i]));
    end
    chk("cap_done_lag", 32'(capture_done), 32'h0);
    step();
    chk("cap_done", 32'(capture_done), 32'h1);
    engine_active = 1'b0;
    step();
    chk("cap_hold_mask", 32'(capture_mask), 32'hFF);
    engine_active = 1'b1;
    step();
    chk("cap_clr_mask", 32'(capture_mask), 32'h0);
    chk("cap_clr_done", 32'(capture_done), 32'h0);

    // Arbitration: engine blocks host for 10 cycles
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'd5;
    gnt_seen = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (host_gnt !== 1'b0 || host_rvalid !== 1'b0) gnt_seen++;
      step();
    end
    chk("arb_blocked", 32'(gnt_seen), 32'h0);
    engine_active = 1'b0;
    #1;
    chk("arb_gnt_fall", 32'(host_gnt), 32'h1);
    step();
    host_req = 1'b0;
    chk("arb_rvalid", 32'(host_rvalid), 32'h1);
    chk("arb_rdata", host_rdata, 32'h5);
    chk("err_clean", 32'(err_oob), 32'h0);

    // Out-of-range host read and engine write
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0400;
    step();
    host_req = 1'b0;
    chk("oob_rdata", host_rdata, 32'hDEADBEEF);
    chk("oob_err", 32'(err_oob), 32'h1);
    step(); step();
    chk("oob_err_sticky", 32'(err_oob), 32'h1);
    out_base = 16'hFFFC;
    engine_active = 1'b1;
    step();
    eng_write(16'hFFFF, 32'h11111111);
    chk("oob_eng_rd", mem_read_data, 32'hDEADBEEF);
    chk("oob_no_cap", 32'(capture_mask), 32'h0);
    eng_write(16'h0000, 32'h0);
    chk("nowrap_no_cap", 32'(capture_mask), 32'h0);

    // Async reset mid-traffic; array survives, in-flight read is lost
    engine_active = 1'b0;
    host_write(16'd10, 32'h12345678);
    mem_addr = 16'd7;
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'd10;
    step();
    chk("pre_rst_eng", mem_read_data, 32'hA5A5A5A5);
    #2 reset_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    host_req = 1'b0;
    #1 reset_n = 1'b1;
    step();
    chk("rst_no_rvalid", 32'(host_rvalid), 32'h0);
    chk("rst_eng_keep", mem_read_data, 32'hA5A5A5A5);
    host_req = 1'b1; host_addr = 16'd10;
    step();
    host_req = 1'b0;
    chk("rst_host_keep", host_rdata, 32'h12345678);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
